uart_packet_framer: RTL and testbench

- Downstream stage of the read/write controllers. Consumes the UART_PACKET beat stream they produce and serialises it into bytes for the UART transmitter.
- Frame format on the wire: SYNC, Destination, Source, Length, then Length data bytes.
- Provides beat-level backpressure to upstream through opTxReady.
- Guarantees a well-formed frame on the wire even when the upstream stream is malformed.

---
 rtl/uart_packet_framer_pkg.sv | 34 +++
 rtl/uart_packet_framer_pacer.sv | 23 ++
 rtl/uart_packet_framer.sv | 183 ++++++++++++++++++
 tb/tb_uart_packet_framer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_packet_framer_pkg.sv
// Shared types and constants for the UART packet framer: beat format,
// framer state encoding and default sync/pad bytes.
package uart_packet_framer_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DEST,
        ST_SRC,
        ST_LEN,
        ST_DATA,
        ST_PAD,
        ST_DROP
    } framer_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam logic [7:0] PAD_BYTE_DEFAULT  = 8'h00;

    // A Length field of zero encodes a 256-byte payload.
    function automatic logic [8:0] frame_len(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_packet_framer_pacer.sv
// Send pacing: a byte may go out only when the transmitter is not busy and
// no byte went out in the previous cycle (covers the transmitter's busy latency).
module tx_send_pacer (
    input  logic clk,
    input  logic rst_n,
    input  logic request,
    input  logic busy,
    output logic grant
);

    logic grant_prev_reg;

    assign grant = request && !busy && !grant_prev_reg && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_prev_reg <= 1'b0;
        end else begin
            grant_prev_reg <= grant;
        end
    end

endmodule

// File: rtl/uart_packet_framer.sv
// Serialises UART_PACKET beats into SYNC/Dest/Src/Len/Data bytes, padding short
// packets and dropping overlong ones so every frame on the wire is well formed.
module uart_packet_framer
    import uart_packet_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEFAULT
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  UART_PACKET ipTxStream,
    output logic       opTxReady,
    output logic [7:0] opTxData,
    output logic       opTxSend,
    input  logic       ipTxBusy,
    output logic       opFrameError,
    output logic       opIdle
);

    framer_state_t state_reg, state_next;
    logic [7:0]    dest_reg, dest_next;
    logic [7:0]    src_reg, src_next;
    logic [7:0]    len_reg, len_next;
    logic [8:0]    count_reg, count_next;
    logic [7:0]    hold_reg, hold_next;
    logic          hold_full_reg, hold_full_next;
    logic          hold_eop_reg, hold_eop_next;
    logic          error_reg, error_next;

    logic          ready;
    logic          request;
    logic          grant;
    logic [7:0]    tx_byte;
    logic [8:0]    total;

    assign total = frame_len(len_reg);

    tx_send_pacer u_pacer (
        .clk     (ipClk),
        .rst_n   (ipReset),
        .request (request),
        .busy    (ipTxBusy),
        .grant   (grant)
    );

    always_comb begin
        state_next     = state_reg;
        dest_next      = dest_reg;
        src_next       = src_reg;
        len_next       = len_reg;
        count_next     = count_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        hold_eop_next  = hold_eop_reg;
        error_next     = 1'b0;
        ready          = 1'b0;
        request        = 1'b0;
        tx_byte        = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (ipTxStream.Valid) begin
                    if (ipTxStream.SoP) begin
                        dest_next      = ipTxStream.Destination;
                        src_next       = ipTxStream.Source;
                        len_next       = ipTxStream.Length;
                        hold_next      = ipTxStream.Data;
                        hold_full_next = 1'b1;
                        hold_eop_next  = ipTxStream.EoP;
                        count_next     = 9'd1;
                        state_next     = ST_SYNC;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                request = 1'b1;
                tx_byte = SYNC_BYTE;
                if (grant) state_next = ST_DEST;
            end
            ST_DEST: begin
                request = 1'b1;
                tx_byte = dest_reg;
                if (grant) state_next = ST_SRC;
            end
            ST_SRC: begin
                request = 1'b1;
                tx_byte = src_reg;
                if (grant) state_next = ST_LEN;
            end
            ST_LEN: begin
                request = 1'b1;
                tx_byte = len_reg;
                if (grant) state_next = ST_DATA;
            end
            ST_DATA: begin
                request = hold_full_reg;
                tx_byte = hold_reg;
                if (hold_full_reg) begin
                    // Frame decisions are taken when the held byte leaves.
                    if (grant) begin
                        hold_full_next = 1'b0;
                        if (hold_eop_reg) begin
                            if (count_reg == total) begin
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_PAD;
                                error_next = 1'b1;
                            end
                        end else if (count_reg == total) begin
                            state_next = ST_DROP;
                            error_next = 1'b1;
                        end
                    end
                end else if (ipTxStream.Valid && ipTxStream.SoP) begin
                    // Leave the new packet's SoP beat for IDLE to pick up.
                    state_next = ST_PAD;
                    error_next = 1'b1;
                end else begin
                    ready = 1'b1;
                    if (ipTxStream.Valid) begin
                        hold_next      = ipTxStream.Data;
                        hold_full_next = 1'b1;
                        hold_eop_next  = ipTxStream.EoP;
                        count_next     = count_reg + 9'd1;
                    end
                end
            end
            ST_PAD: begin
                request = 1'b1;
                tx_byte = PAD_BYTE;
                if (grant) begin
                    count_next = count_reg + 9'd1;
                    if (count_reg + 9'd1 == total) state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (ipTxStream.Valid && ipTxStream.SoP) begin
                    state_next = ST_IDLE;
                end else begin
                    ready = 1'b1;
                    if (ipTxStream.Valid && ipTxStream.EoP) state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_reg     <= ST_IDLE;
            dest_reg      <= 8'h00;
            src_reg       <= 8'h00;
            len_reg       <= 8'h00;
            count_reg     <= 9'd0;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
            hold_eop_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dest_reg      <= dest_next;
            src_reg       <= src_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            hold_eop_reg  <= hold_eop_next;
            error_reg     <= error_next;
        end
    end

    assign opTxReady    = ready && ipReset;
    assign opTxSend     = grant;
    assign opTxData     = grant ? tx_byte : 8'h00;
    assign opFrameError = error_reg;
    assign opIdle       = (state_reg == ST_IDLE) || !ipReset;

endmodule

// File: tb/tb_uart_packet_framer.sv
// Self-checking bench: a packet-level model turns the beat list into the
// expected byte stream and error count; a monitor checks every send.
module tb_uart_packet_framer;
    import uart_packet_framer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    UART_PACKET stream;
    logic       busy;
    logic       ready, send, ferr, idle;
    logic [7:0] txd;

    always #5 clk = ~clk;

    uart_packet_framer dut (
        .ipClk        (clk),
        .ipReset      (rst_n),
        .ipTxStream   (stream),
        .opTxReady    (ready),
        .opTxData     (txd),
        .opTxSend     (send),
        .ipTxBusy     (busy),
        .opFrameError (ferr),
        .opIdle       (idle)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;
    int         err_seen = 0;
    int         sent_idx = 0;
    int         exp_rd = 0;
    int         send_cyc[$];
    logic [7:0] exp_bytes[$];
    logic       prev_send = 1'b0;
    logic       chk_hdr = 1'b0;
    int         hdr_base = 0;
    int         busy_mode = 0;
    int         busy_cnt = 0;
    int         first_accept_cyc = 0;
    UART_PACKET stim[$];
    logic [7:0] mdl_bytes[$];
    int         mdl_errs = 0;
    logic [7:0] lit_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic UART_PACKET beat(input logic [7:0] dst, input logic [7:0] src,
                                        input logic [7:0] len, input logic [7:0] dat,
                                        input logic sop, input logic eop);
        UART_PACKET b;
        b.Destination = dst;
        b.Source      = src;
        b.Length      = len;
        b.Data        = dat;
        b.SoP         = sop;
        b.EoP         = eop;
        b.Valid       = 1'b1;
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every send is checked against the expected byte stream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (send) begin
                check("send_rule_busy_or_gap", 32'({busy, prev_send}), 32'd0);
                if (exp_rd >= exp_bytes.size()) begin
                    check("unexpected_send", 32'(send), 32'd0);
                end else begin
                    check("tx_byte", 32'(txd), 32'(exp_bytes[exp_rd]));
                    exp_rd <= exp_rd + 1;
                end
                sent_idx <= sent_idx + 1;
                send_cyc.push_back(cyc);
            end
            if (chk_hdr && (sent_idx - hdr_base) >= 1 && (sent_idx - hdr_base) <= 3)
                check("ready_in_header", 32'(ready), 32'd0);
            if (ferr) err_seen <= err_seen + 1;
        end
        prev_send <= send;
    end

    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                0: busy = 1'b0;
                1: busy = ($urandom_range(3) == 0);
                default: begin
                    if (prev_send) busy_cnt = 10;
                    busy = (busy_cnt > 0);
                    if (busy_cnt > 0) busy_cnt--;
                end
            endcase
        end
    end

    // Packet-level reference: walk the beat list the way the frame rules read.
    task automatic run_model();
        int i;
        int n;
        int flen;
        int cnt;
        bit ended;
        i = 0;
        n = stim.size();
        mdl_bytes.delete();
        mdl_errs = 0;
        while (i < n) begin
            if (!stim[i].SoP) begin
                mdl_errs++;
                i++;
                continue;
            end
            flen = (stim[i].Length == 8'd0) ? 256 : int'(stim[i].Length);
            mdl_bytes.push_back(8'h55);
            mdl_bytes.push_back(stim[i].Destination);
            mdl_bytes.push_back(stim[i].Source);
            mdl_bytes.push_back(stim[i].Length);
            mdl_bytes.push_back(stim[i].Data);
            cnt = 1;
            ended = stim[i].EoP;
            i++;
            while (cnt < flen && !ended && i < n && !stim[i].SoP) begin
                mdl_bytes.push_back(stim[i].Data);
                ended = stim[i].EoP;
                i++;
                cnt++;
            end
            if (cnt < flen) begin
                mdl_errs++;
                repeat (flen - cnt) mdl_bytes.push_back(8'h00);
            end else if (!ended) begin
                mdl_errs++;
                while (i < n && !stim[i].SoP) begin
                    ended = stim[i].EoP;
                    i++;
                    if (ended) break;
                end
            end
        end
    endtask

    task automatic pin_model(input string name, input int lit_err);
        run_model();
        check({name, "_model_len"}, 32'(mdl_bytes.size()), 32'(lit_q.size()));
        for (int k = 0; k < lit_q.size() && k < mdl_bytes.size(); k++)
            check({name, "_model_byte"}, 32'(mdl_bytes[k]), 32'(lit_q[k]));
        check({name, "_model_err"}, 32'(mdl_errs), 32'(lit_err));
    endtask

    task automatic drive_stim(input int gap_pct);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < stim.size() && guard < 20000) begin
            @(posedge clk);
            #1;
            if ($urandom_range(99) < gap_pct) begin
                stream = '0;
            end else begin
                stream = stim[idx];
                stream.Valid = 1'b1;
            end
            @(negedge clk);
            if (stream.Valid && ready) begin
                if (idx == 0) first_accept_cyc = cyc;
                idx++;
            end
            guard++;
        end
        check("drive_budget", 32'(guard < 20000), 32'd1);
        @(posedge clk);
        #1;
        stream = '0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(exp_rd == exp_bytes.size() && idle) && guard < 5000);
        check("drain_timeout", 32'(guard < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_test(input string name, input int gap_pct, input int mode);
        int e0;
        run_model();
        busy_mode = mode;
        foreach (mdl_bytes[k]) exp_bytes.push_back(mdl_bytes[k]);
        e0 = err_seen;
        drive_stim(gap_pct);
        wait_drain();
        check({name, "_error_pulses"}, 32'(err_seen - e0), 32'(mdl_errs));
        check({name, "_bytes_left"}, 32'(exp_bytes.size() - exp_rd), 32'd0);
    endtask

    task automatic gen_random(input int npk);
        int kind;
        int flen;
        int nb;
        logic [7:0] d;
        logic [7:0] s;
        stim.delete();
        for (int p = 0; p < npk; p++) begin
            kind = (p == npk - 1) ? 0 : int'($urandom_range(4));
            flen = int'($urandom_range(2, 6));
            d = 8'($urandom);
            s = 8'($urandom);
            case (kind)
                0: nb = flen;
                1: nb = int'($urandom_range(1, flen - 1));
                2: nb = flen + int'($urandom_range(1, 3));
                3: nb = int'($urandom_range(1, 2));
                default: nb = int'($urandom_range(1, flen - 1));
            endcase
            for (int b = 0; b < nb; b++) begin
                if (kind == 3)
                    stim.push_back(beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                        1'b0, 1'($urandom_range(1))));
                else if (b == 0)
                    stim.push_back(beat(d, s, 8'(flen), 8'($urandom), 1'b1,
                                        (kind != 4) && (nb == 1)));
                else
                    stim.push_back(beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                        1'b0, (kind != 4) && (b == nb - 1)));
            end
        end
    endtask

    task automatic load_nominal();
        stim.delete();
        stim.push_back(beat(8'h00, 8'h01, 8'h04, 8'h11, 1'b1, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h44, 1'b0, 1'b1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        rst_n = 1'b0;
        stream = '0;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_send", 32'(send), 32'd0);
        check("reset_data", 32'(txd), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        check("reset_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready), 32'd1);
        check("idle_after_reset", 32'(idle), 32'd1);

        // Nominal frame, back-to-back beats, transmitter never busy.
        load_nominal();
        lit_q = '{8'h55, 8'h00, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        pin_model("nominal", 0);
        base = send_cyc.size();
        run_test("nominal", 0, 0);
        check("nominal_sends", 32'(send_cyc.size() - base), 32'd8);
        if (send_cyc.size() >= base + 8) begin
            check("sync_latency", 32'(send_cyc[base] - first_accept_cyc), 32'd1);
            for (int k = 1; k < 8; k++)
                check("byte_spacing", 32'(send_cyc[base + k] - send_cyc[base + k - 1]), 32'd2);
        end
        check("idle_after_nominal", 32'(idle), 32'd1);

        // Backpressure: busy for 10 cycles after each send, ragged valid.
        load_nominal();
        hdr_base = sent_idx;
        chk_hdr = 1'b1;
        run_test("backpressure", 30, 2);
        chk_hdr = 1'b0;

        // Short packet: EoP on the 2nd beat of a Len=4 packet.
        stim.delete();
        stim.push_back(beat(8'h00, 8'h01, 8'h04, 8'h11, 1'b1, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b1));
        lit_q = '{8'h55, 8'h00, 8'h01, 8'h04, 8'h11, 8'h22, 8'h00, 8'h00};
        pin_model("short", 1);
        run_test("short", 20, 1);

        // Long packet: Len=2 with four beats.
        stim.delete();
        stim.push_back(beat(8'h00, 8'h01, 8'h02, 8'h11, 1'b1, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h44, 1'b0, 1'b1));
        lit_q = '{8'h55, 8'h00, 8'h01, 8'h02, 8'h11, 8'h22};
        pin_model("long", 1);
        run_test("long", 20, 1);
        check("idle_after_long", 32'(idle), 32'd1);

        // Stray beat in IDLE, then a SoP cutting a Len=3 frame after one byte.
        stim.delete();
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'h99, 1'b0, 1'b0));
        stim.push_back(beat(8'h00, 8'h01, 8'h03, 8'h11, 1'b1, 1'b0));
        stim.push_back(beat(8'h00, 8'h01, 8'h02, 8'hAA, 1'b1, 1'b0));
        stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'hBB, 1'b0, 1'b1));
        lit_q = '{8'h55, 8'h00, 8'h01, 8'h03, 8'h11, 8'h00, 8'h00,
                  8'h55, 8'h00, 8'h01, 8'h02, 8'hAA, 8'hBB};
        pin_model("stray_midsop", 2);
        run_test("stray_midsop", 0, 0);

        // Reset one cycle while the frame sits in DEST.
        busy_mode = 0;
        exp_bytes.push_back(8'h55);
        base = sent_idx;
        @(posedge clk);
        #1;
        stream = beat(8'h00, 8'h01, 8'h04, 8'h11, 1'b1, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!ready && guard < 50);
        @(posedge clk);
        #1;
        stream = '0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (sent_idx == base && guard < 50);
        check("reset_test_sync_sent", 32'(sent_idx - base), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_send", 32'(send), 32'd0);
        check("midreset_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_midreset_ready", 32'(ready), 32'd1);
        check("after_midreset_idle", 32'(idle), 32'd1);
        base = sent_idx;
        repeat (20) @(negedge clk);
        check("no_send_after_reset", 32'(sent_idx - base), 32'd0);
        load_nominal();
        run_test("post_reset_nominal", 10, 1);

        // Len=0 means 256 data bytes.
        stim.delete();
        stim.push_back(beat(8'h10, 8'h20, 8'h00, 8'($urandom), 1'b1, 1'b0));
        for (int k = 1; k < 256; k++)
            stim.push_back(beat(8'h00, 8'h00, 8'h00, 8'($urandom), 1'b0, k == 255));
        run_model();
        check("len0_model_len", 32'(mdl_bytes.size()), 32'd260);
        check("len0_model_lenbyte", 32'(mdl_bytes[3]), 32'd0);
        check("len0_model_err", 32'(mdl_errs), 32'd0);
        run_test("len0", 10, 1);

        // Randomized mixes of well-formed and malformed packets.
        for (int r = 0; r < 4; r++) begin
            gen_random(12);
            run_test("random", 25, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
